sap_core_param: RTL

// - Parametrised SAP-class CPU core: one block integrating PC, MAR, RAM,
//   IR, A/B registers, adder-subtractor, output register and a one-hot
//   T-state sequencer.
// - Extends the SAP-1 datapath with configurable widths, Z/C flags,

---
 rtl/sap_core_param.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/sap_core_param.sv
// Parametrised SAP-class CPU core: PC, MAR, RAM, IR, A/B, adder-subtractor, output register, one-hot T1..T6 sequencer.
// Optional feature macro: SAP_BRANCH_EN (JMP/JZ/JC); when undefined those opcodes execute as NOPs.
module sap_core_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              prog_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] display,
  output logic              out_valid,
  output logic              halted,
  output logic [5:0]        t_state
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  localparam int RAM_D = 1 << ADDR_W;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
`ifdef SAP_BRANCH_EN
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_JZ  = 4'b0100;
  localparam logic [3:0] OP_JC  = 4'b0101;
`endif
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] mem_r [RAM_D];

  tstate_e           t_state_r, t_state_s;
  logic [ADDR_W-1:0] pc_r, pc_s;
  logic [ADDR_W-1:0] mar_r, mar_s;
  logic [DATA_W-1:0] ir_r, ir_s;
  logic [DATA_W-1:0] a_r, a_s;
  logic [DATA_W-1:0] b_r, b_s;
  logic              z_r, z_s;
  logic              c_r, c_s;
  logic [DATA_W-1:0] display_r, display_s;
  logic              out_valid_r, out_valid_s;
  logic              halted_r, halted_s;

  logic [DATA_W-1:0] ram_rd_s;
  logic [3:0]        opcode_s;
  logic [ADDR_W-1:0] operand_s;
  logic [DATA_W:0]   sum_s;
  logic [DATA_W-1:0] diff_s;

  assign ram_rd_s  = mem_r[mar_r];
  assign opcode_s  = ir_r[DATA_W-1 -: 4];
  assign operand_s = ir_r[ADDR_W-1:0];
  assign sum_s     = {1'b0, a_r} + {1'b0, b_r};
  assign diff_s    = a_r - b_r;

  // Program RAM: written only through the programming port, never reset.
  always_ff @(posedge CLK) begin
    if (prog_mode && prog_we) begin
      mem_r[prog_addr] <= prog_data;
    end
  end

  // Next-state and datapath update for the T-state sequencer.
  always_comb begin
    t_state_s   = t_state_r;
    pc_s        = pc_r;
    mar_s       = mar_r;
    ir_s        = ir_r;
    a_s         = a_r;
    b_s         = b_r;
    z_s         = z_r;
    c_s         = c_r;
    display_s   = display_r;
    out_valid_s = 1'b0;
    halted_s    = halted_r;

    if (prog_mode) begin
      // Programming idles the core but keeps the last displayed value.
      t_state_s = T1;
      pc_s      = ADDR_ZERO;
      mar_s     = ADDR_ZERO;
      ir_s      = DATA_ZERO;
      a_s       = DATA_ZERO;
      b_s       = DATA_ZERO;
      z_s       = 1'b0;
      c_s       = 1'b0;
      halted_s  = 1'b0;
    end else if (halted_r) begin
      t_state_s = t_state_r;
    end else begin
      case (t_state_r)
        T1: begin
          mar_s     = pc_r;
          t_state_s = T2;
        end
        T2: begin
          pc_s      = pc_r + ADDR_ONE;
          t_state_s = T3;
        end
        T3: begin
          ir_s      = ram_rd_s;
          t_state_s = T4;
        end
        T4: begin
          t_state_s = T5;
          case (opcode_s)
            OP_LDA, OP_ADD, OP_SUB: mar_s = operand_s;
`ifdef SAP_BRANCH_EN
            OP_JMP: pc_s = operand_s;
            OP_JZ:  pc_s = z_r ? operand_s : pc_r;
            OP_JC:  pc_s = c_r ? operand_s : pc_r;
`endif
            OP_OUT: begin
              display_s   = a_r;
              out_valid_s = 1'b1;
            end
            OP_HLT: begin
              halted_s  = 1'b1;
              t_state_s = T4;
            end
            default: mar_s = mar_r;
          endcase
        end
        T5: begin
          t_state_s = T6;
          case (opcode_s)
            OP_LDA:         a_s = ram_rd_s;
            OP_ADD, OP_SUB: b_s = ram_rd_s;
            default:        b_s = b_r;
          endcase
        end
        T6: begin
          t_state_s = T1;
          case (opcode_s)
            OP_ADD: begin
              a_s = sum_s[DATA_W-1:0];
              c_s = sum_s[DATA_W];
              z_s = (sum_s[DATA_W-1:0] == DATA_ZERO);
            end
            OP_SUB: begin
              a_s = diff_s;
              c_s = (a_r >= b_r);
              z_s = (diff_s == DATA_ZERO);
            end
            default: a_s = a_r;
          endcase
        end
        default: t_state_s = T1;
      endcase
    end
  end

  // Architectural register bank with asynchronous clear.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      t_state_r   <= T1;
      pc_r        <= ADDR_ZERO;
      mar_r       <= ADDR_ZERO;
      ir_r        <= DATA_ZERO;
      a_r         <= DATA_ZERO;
      b_r         <= DATA_ZERO;
      z_r         <= 1'b0;
      c_r         <= 1'b0;
      display_r   <= DATA_ZERO;
      out_valid_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      t_state_r   <= t_state_s;
      pc_r        <= pc_s;
      mar_r       <= mar_s;
      ir_r        <= ir_s;
      a_r         <= a_s;
      b_r         <= b_s;
      z_r         <= z_s;
      c_r         <= c_s;
      display_r   <= display_s;
      out_valid_r <= out_valid_s;
      halted_r    <= halted_s;
    end
  end

  assign display   = display_r;
  assign out_valid = out_valid_r;
  assign halted    = halted_r;
  assign t_state   = t_state_r;

endmodule
